mux4way_rr: RTL and testbench



---
 rtl/mux4way_rr.sv | 118 +++++++++++
 tb/tb_mux4way_rr.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux4way_rr.sv
// rtl/mux4way_rr.sv - four-source round-robin merger into a single tagged output register
module mux4way_rr #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    input  logic [WIDTH-1:0] c_data,
    input  logic [WIDTH-1:0] d_data,
    input  logic             a_valid,
    input  logic             b_valid,
    input  logic             c_valid,
    input  logic             d_valid,
    output logic             a_ready,
    output logic             b_ready,
    output logic             c_ready,
    output logic             d_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    // Occupancy of the output register; EMPTY/FULL is exactly out_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;

    logic [3:0]       valid_vec;
    logic [3:0]       grant;
    logic             grant_any;
    logic [1:0]       grant_idx;
    logic [1:0]       cand;
    logic             load_en;
    logic [WIDTH-1:0] grant_data;

    assign valid_vec = {d_valid, c_valid, b_valid, a_valid};

    // The register can take a word when it is empty or draining this cycle.
    assign load_en = (state_q == ST_EMPTY) || out_ready;

    // Round-robin scan starting at ptr; first valid source wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!grant_any && valid_vec[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // One-hot grant vector and the selected source word.
    always_comb begin
        grant = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
        case (grant_idx)
            2'd0:    grant_data = a_data;
            2'd1:    grant_data = b_data;
            2'd2:    grant_data = c_data;
            default: grant_data = d_data;
        endcase
    end

    // Readies are forced low while reset is asserted, even though the
    // register reads as empty then.
    assign a_ready = rst_n && load_en && grant[0];
    assign b_ready = rst_n && load_en && grant[1];
    assign c_ready = rst_n && load_en && grant[2];
    assign d_ready = rst_n && load_en && grant[3];

    // Next state: load on accept, empty on idle drain, otherwise hold.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            if (grant_any) begin
                state_d = ST_FULL;
                data_d  = grant_data;
                sel_d   = grant_idx;
                ptr_d   = grant_idx + 2'd1;
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    // Output register and priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux4way_rr.sv
// tb/tb_mux4way_rr.sv - directed-vector bench for mux4way_rr
module tb_mux4way_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a_data, b_data, c_data, d_data;
    logic        a_valid, b_valid, c_valid, d_valid;
    logic        a_ready, b_ready, c_ready, d_ready;
    logic [15:0] out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    int n_vec = 0;
    int n_err = 0;

    mux4way_rr #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_data    (a_data),
        .b_data    (b_data),
        .c_data    (c_data),
        .d_data    (d_data),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .c_valid   (c_valid),
        .d_valid   (d_valid),
        .a_ready   (a_ready),
        .b_ready   (b_ready),
        .c_ready   (c_ready),
        .d_ready   (d_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] rdy();
        return {d_ready, c_ready, b_ready, a_ready};
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input logic [3:0] v);
        {d_valid, c_valid, b_valid, a_valid} = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Expected out_sel / data sequence for the fairness run.
    logic [1:0]  exp_seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [15:0] exp_dat [4] = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};

    initial begin
        rst_n = 1'b0;
        a_data = '0; b_data = '0; c_data = '0; d_data = '0;
        set_valid(4'b0001);
        out_ready = 1'b1;
        #3;
        chk("reset_ready", 32'(rdy()), 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_data", 32'(out_data), 32'h0);
        chk("reset_sel", 32'(out_sel), 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // a only
        a_data = 16'h1234;
        set_valid(4'b0001);
        #1 chk("a_only_ready", 32'(rdy()), 32'h1);
        step();
        chk("a_only_valid", 32'(out_valid), 32'h1);
        chk("a_only_data", 32'(out_data), 32'h1234);
        chk("a_only_sel", 32'(out_sel), 32'h0);

        // all four, fairness
        do_reset();
        a_data = 16'h000A; b_data = 16'h000B; c_data = 16'h000C; d_data = 16'h000D;
        set_valid(4'b1111);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1 chk("rr_ready", 32'(rdy()), 32'(4'b0001 << exp_seq[k]));
            step();
            chk("rr_sel", 32'(out_sel), 32'(exp_seq[k]));
            chk("rr_data", 32'(out_data), 32'(exp_dat[exp_seq[k]]));
        end
        // ptr now 2

        // backpressure
        b_data = 16'hBEEF;
        set_valid(4'b0010);
        #1 chk("bp_load_ready", 32'(rdy()), 32'h2);
        step();
        chk("bp_load_sel", 32'(out_sel), 32'h1);
        c_data = 16'h0C0C; d_data = 16'h0D0D;
        set_valid(4'b1100);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready", 32'(rdy()), 32'h0);
            step();
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_data", 32'(out_data), 32'hBEEF);
            chk("bp_sel", 32'(out_sel), 32'h1);
        end
        out_ready = 1'b1;
        #1 chk("bp_rel_ready", 32'(rdy()), 32'h4);
        step();
        chk("bp_rel_sel", 32'(out_sel), 32'h2);
        chk("bp_rel_data", 32'(out_data), 32'h0C0C);
        // ptr now 3

        // pointer wrap
        d_data = 16'hDDDD;
        set_valid(4'b1000);
        #1 chk("wrap_d_ready", 32'(rdy()), 32'h8);
        step();
        chk("wrap_d_sel", 32'(out_sel), 32'h3);
        a_data = 16'h0AAA; c_data = 16'h0CCC;
        set_valid(4'b0101);
        #1 chk("wrap_a_ready", 32'(rdy()), 32'h1);
        step();
        chk("wrap_a_sel", 32'(out_sel), 32'h0);
        chk("wrap_a_data", 32'(out_data), 32'h0AAA);
        #1 chk("wrap_c_ready", 32'(rdy()), 32'h4);
        step();
        chk("wrap_c_sel", 32'(out_sel), 32'h2);
        chk("wrap_c_data", 32'(out_data), 32'h0CCC);

        // drain to empty
        c_data = 16'h0C00;
        set_valid(4'b0100);
        step();
        chk("drain_valid1", 32'(out_valid), 32'h1);
        chk("drain_data1", 32'(out_data), 32'h0C00);
        set_valid(4'b0000);
        #1 chk("drain_ready", 32'(rdy()), 32'h0);
        step();
        chk("drain_valid0", 32'(out_valid), 32'h0);
        chk("drain_hold", 32'(out_data), 32'h0C00);
        chk("drain_sel", 32'(out_sel), 32'h2);

        // async reset mid-stream
        c_data = 16'h0C11;
        set_valid(4'b0100);
        step();
        chk("ar_full_sel", 32'(out_sel), 32'h2);
        out_ready = 1'b0;
        set_valid(4'b1111);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'h0);
        chk("ar_sel", 32'(out_sel), 32'h0);
        chk("ar_data", 32'(out_data), 32'h0);
        chk("ar_ready", 32'(rdy()), 32'h0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        a_data = 16'h000A; b_data = 16'h000B; c_data = 16'h000C; d_data = 16'h000D;
        #1 chk("ar_first_ready", 32'(rdy()), 32'h1);
        step();
        chk("ar_first_sel", 32'(out_sel), 32'h0);
        chk("ar_first_data", 32'(out_data), 32'h000A);
        step();
        chk("ar_second_sel", 32'(out_sel), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
